alu_mc: RTL and testbench

Parametrised multicycle ALU for the multicycle CPU datapath, replacing the combinational ADD/SUB/OR/SLT unit. Single-cycle ops (ADD, SUB, OR, AND, SLT) return a registered result one cycle after `start`. Iterative unsigned multiply and divide take WIDTH+1 cycles through a shared shift engine. A start/busy/done handshake lets the control FSM stall the execute state until `done`.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/mdu_iter.sv | 70 +++++++
 rtl/alu_mc.sv | 138 +++++++++++++
 tb/tb_alu_mc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op codes, FSM state type and helpers.
package alu_pkg;

  localparam int unsigned ALUOP_W = 3;

  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t ALU_ADD  = 3'b000;
  localparam aluop_t ALU_SUB  = 3'b001;
  localparam aluop_t ALU_OR   = 3'b010;
  localparam aluop_t ALU_SLT  = 3'b011;
  localparam aluop_t ALU_AND  = 3'b100;
  localparam aluop_t ALU_MULU = 3'b101;
  localparam aluop_t ALU_DIVU = 3'b110;
  localparam aluop_t ALU_RSVD = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } state_e;

  // Ops that run through the shift engine, unless short-circuited (divide by zero).
  function automatic logic is_iter_op(aluop_t op);
    return (op == ALU_MULU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Shared shift engine: unsigned shift-add multiply and restoring divide, one bit per step.
module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] b_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  // Multiply: {acc, sh} shifts right as partial products accumulate.
  // Divide: {acc, sh} shifts left; acc is the partial remainder, sh collects quotient bits.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q, sh_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ge   = ~div_diff[WIDTH];
    if (div_q) begin
      acc_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = mul_sum[WIDTH:1];
      sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      sh_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= '0;
      sh_q  <= a_i;
      b_q   <= b_i;
      div_q <= div_i;
      cnt_q <= CNT_W'(WIDTH);
    end else if (step_i) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Post-step values, so the final step can be committed on the same edge.
  assign last_o = (cnt_q == CNT_W'(1));
  assign lo_o   = sh_d;
  assign hi_o   = acc_d;

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle ops plus iterative MULU/DIVU behind a start/busy/done handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [WIDTH-1:0]   data1_i,
  input  logic [WIDTH-1:0]   data2_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic               zero_o,
  output logic               more_o
);

  state_e state_q, state_d;

  logic             accept;
  logic             iter_start;
  logic             div0;
  logic             eng_load, eng_step, eng_last;
  logic             wr_sc, wr_it;
  logic [WIDTH-1:0] eng_lo, eng_hi;
  logic [WIDTH-1:0] sum, diff;
  logic             slt_ovf;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             data1_pos;

  logic [WIDTH-1:0] result_q, hi_q;
  logic             zero_q, more_q, more_pend_q;

  // Single-cycle datapath.
  always_comb begin
    sum     = data1_i + data2_i;
    diff    = data1_i - data2_i;
    slt_ovf = (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]) & (diff[WIDTH-1] ^ data1_i[WIDTH-1]);
    div0    = (data2_i == '0);
    sc_res  = '0;
    sc_hi   = '0;
    unique case (aluop_i)
      ALU_ADD:  sc_res = sum;
      ALU_SUB:  sc_res = diff;
      ALU_OR:   sc_res = data1_i | data2_i;
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ slt_ovf};
      ALU_AND:  sc_res = data1_i & data2_i;
      ALU_DIVU: begin
        sc_res = '1;
        sc_hi  = data1_i;
      end
      default: ;
    endcase
    iter_start = is_iter_op(aluop_i) & ~((aluop_i == ALU_DIVU) & div0);
    data1_pos  = ~data1_i[WIDTH-1] & (|data1_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) state_d = iter_start ? StIter : StDone;
      end
      StIter: begin
        if (flush_i)       state_d = StIdle;
        else if (eng_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    accept   = (state_q == StIdle) & start_i & ~flush_i;
    eng_load = accept & iter_start;
    wr_sc    = accept & ~iter_start;
    eng_step = (state_q == StIter) & ~flush_i;
    wr_it    = eng_step & eng_last;
    busy_o   = (state_q != StIdle);
    done_o   = (state_q == StDone);
  end

  mdu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mdu_iter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (eng_load),
    .step_i (eng_step),
    .div_i  (aluop_i == ALU_DIVU),
    .a_i    (data1_i),
    .b_i    (data2_i),
    .last_o (eng_last),
    .lo_o   (eng_lo),
    .hi_o   (eng_hi)
  );

  // more is latched at accept but only published together with the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b1;
      more_q      <= 1'b0;
      more_pend_q <= 1'b0;
    end else begin
      if (eng_load) more_pend_q <= data1_pos;
      if (wr_sc) begin
        result_q <= sc_res;
        hi_q     <= sc_hi;
        zero_q   <= (sc_res == '0);
        more_q   <= data1_pos;
      end else if (wr_it) begin
        result_q <= eng_lo;
        hi_q     <= eng_hi;
        zero_q   <= (eng_lo == '0);
        more_q   <= more_pend_q;
      end
    end
  end

  assign result_o = result_q;
  assign hi_o     = hi_q;
  assign zero_o   = zero_q;
  assign more_o   = more_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised self-checking bench for alu_mc at WIDTH=32 and WIDTH=8.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush;
  logic          start, busy, done, zero, more;
  logic [2:0]    aluop;
  logic [W-1:0]  d1, d2, result, hi;
  logic          start8, busy8, done8, zero8, more8;
  logic [2:0]    aluop8;
  logic [W8-1:0] a8, b8, result8, hi8;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] last_res, last_hi;

  alu_mc #(.WIDTH(W)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .flush_i(flush), .aluop_i(aluop),
    .data1_i(d1), .data2_i(d2), .busy_o(busy), .done_o(done), .result_o(result),
    .hi_o(hi), .zero_o(zero), .more_o(more)
  );

  alu_mc #(.WIDTH(W8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .flush_i(flush), .aluop_i(aluop8),
    .data1_i(a8), .data2_i(b8), .busy_o(busy8), .done_o(done8), .result_o(result8),
    .hi_o(hi8), .zero_o(zero8), .more_o(more8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the op definitions, using plain wide arithmetic.
  function automatic void model(input int w, input logic [2:0] op, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] res,
                                output logic [63:0] hv, output int lat);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint sa, sb;
    longint unsigned p;
    sa  = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb  = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    res = 0;
    hv  = 0;
    lat = 1;
    case (op)
      3'd0: res = (a + b) & mask;
      3'd1: res = (a - b) & mask;
      3'd2: res = a | b;
      3'd3: res = (sa < sb) ? 64'd1 : 64'd0;
      3'd4: res = a & b;
      3'd5: begin
        p   = a * b;
        res = p & mask;
        hv  = p >> w;
        lat = w + 1;
      end
      3'd6: begin
        if (b == 0) begin
          res = mask;
          hv  = a;
        end else begin
          res = a / b;
          hv  = a % b;
          lat = w + 1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(5, 0))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(15, 0);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at a negedge, wait for done (bounded), check everything, return to idle.
  task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit junk, input string tag);
    int w, k, lat;
    logic [63:0] er, eh, am;
    logic cur_done;
    w  = w8 ? W8 : W;
    am = w8 ? 64'(a[7:0]) : 64'(a);
    model(w, op, am, w8 ? 64'(b[7:0]) : 64'(b), er, eh, lat);
    if (w8) begin
      aluop8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end else begin
      aluop = op; d1 = a; d2 = b; start = 1'b1;
    end
    k = 0;
    cur_done = 1'b0;
    while (k < 200 && !cur_done) begin
      @(negedge clk);
      k++;
      cur_done = w8 ? done8 : done;
      start8   = 1'b0;
      start    = 1'b0;
      // Requests while busy must be dropped without disturbing the op in flight.
      if (!w8 && !cur_done && junk && $urandom_range(1, 0) == 1) begin
        start = 1'b1;
        aluop = 3'($urandom_range(7, 0));
        d1    = $urandom;
        d2    = $urandom;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(k), 64'(lat));
    if (w8) begin
      check({tag, " result"}, 64'(result8), er);
      check({tag, " hi"}, 64'(hi8), eh);
      check({tag, " zero"}, 64'(zero8), 64'(er == 0));
      check({tag, " more"}, 64'(more8), 64'(am[w-1] == 1'b0 && am != 0));
    end else begin
      check({tag, " result"}, 64'(result), er);
      check({tag, " hi"}, 64'(hi), eh);
      check({tag, " zero"}, 64'(zero), 64'(er == 0));
      check({tag, " more"}, 64'(more), 64'(am[w-1] == 1'b0 && am != 0));
    end
    @(negedge clk);
    check({tag, " done pulse"}, 64'(w8 ? done8 : done), 64'd0);
    check({tag, " idle"}, 64'(w8 ? busy8 : busy), 64'd0);
    check({tag, " held"}, 64'(w8 ? result8 : result), er);
    last_res = er;
    last_hi  = eh;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    start = 1'b1; aluop = ALU_ADD; d1 = 32'd1; d2 = 32'd2;
    start8 = 1'b0; aluop8 = ALU_ADD; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst zero", 64'(zero), 64'd1);
    check("rst more", 64'(more), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first start done", 64'(done), 64'd1);
    check("first start result", 64'(result), 64'd3);
    @(negedge clk);

    run_op(1'b0, ALU_SLT, 32'h8000_0000, 32'd1, 1'b0, "slt min");
    run_op(1'b0, ALU_SUB, 32'd5, 32'd5, 1'b0, "sub zero");
    run_op(1'b0, ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mulu max");
    run_op(1'b0, ALU_DIVU, 32'd100, 32'd7, 1'b1, "divu 100/7");
    run_op(1'b0, ALU_DIVU, 32'd9, 32'd0, 1'b0, "divu by0");
    run_op(1'b0, ALU_RSVD, 32'd123, 32'd45, 1'b0, "rsvd");
    run_op(1'b0, ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "slt ovf");

    for (int i = 0; i < 40; i++) begin
      run_op(1'b0, 3'($urandom_range(7, 0)), rnd_operand(), rnd_operand(), 1'b1, "rand");
    end

    // Abort a multiply partway through.
    aluop = ALU_MULU; d1 = $urandom; d2 = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush result", 64'(result), last_res);
    check("flush hi", 64'(hi), last_hi);
    run_op(1'b0, ALU_ADD, 32'd3, 32'd4, 1'b0, "add after flush");

    // Flush and start together: the start is dropped.
    aluop = ALU_ADD; d1 = 32'd10; d2 = 32'd20; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", 64'(busy), 64'd0);
    check("flush+start result", 64'(result), 64'd7);

    // Reset in the middle of a divide.
    aluop = ALU_DIVU; d1 = 32'hDEAD_BEEF; d2 = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst result", 64'(result), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst zero", 64'(zero), 64'd1);
    check("midrst more", 64'(more), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b1, ALU_MULU, 32'hFF, 32'hFF, 1'b0, "w8 mulu max");
    run_op(1'b1, ALU_DIVU, 32'd200, 32'd7, 1'b0, "w8 divu");
    run_op(1'b1, ALU_SLT, 32'h80, 32'h01, 1'b0, "w8 slt");
    for (int i = 0; i < 10; i++) begin
      run_op(1'b1, 3'($urandom_range(7, 0)), $urandom, $urandom, 1'b0, "w8 rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
